cpu_trace_monitor: RTL and testbench

- Parametrised, synthesizable run monitor for the multi-cycle CPU. Successor to the fixed clock/reset simulation harness.
- Watches the CPU commit strobe and captures one trace entry per executed instruction into a circular buffer. Counts cycles and instructions, and detects halt and watchdog timeout.
- Sits beside the CPU core. Usable both in simulation benches and on-board, drained through a valid-handshake read port.

---
 rtl/cpu_trace_monitor.sv | 130 +++++++++++++
 tb/tb_cpu_trace_monitor.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_trace_monitor.sv
// Run monitor for the multi-cycle CPU: records one {PC, write-back} entry per commit in a
// circular buffer, counts cycles/commits, and flags halt or watchdog timeout.
module cpu_trace_monitor #(
    parameter int          PC_WIDTH    = 32,
    parameter int          DATA_WIDTH  = 32,
    parameter int          DEPTH       = 16,
    parameter int          TIMEOUT     = 1024,
    parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             start,
    input  logic                             PCWre,
    input  logic [5:0]                       opCode,
    input  logic [PC_WIDTH-1:0]              currentPC,
    input  logic [DATA_WIDTH-1:0]            DBOut,
    input  logic                             rd_en,
    output logic [PC_WIDTH+DATA_WIDTH-1:0]   rd_data,
    output logic                             rd_valid,
    output logic [$clog2(DEPTH+1)-1:0]       count,
    output logic                             overflow,
    output logic [31:0]                      cycle_count,
    output logic [31:0]                      instr_count,
    output logic [1:0]                       mon_state,
    output logic                             done,
    output logic                             timed_out
);

    // state      | meaning
    // ST_IDLE    | waiting for start, commits ignored
    // ST_RUN     | tracing commits, counting cycles, watchdog armed
    // ST_HALTED  | halt opcode committed, counters frozen
    // ST_TIMEOUT | watchdog expired, counters frozen

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int WW = $clog2(TIMEOUT);
    localparam int EW = PC_WIDTH + DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_HALTED  = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    state_t          state, state_next;
    logic [EW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [WW-1:0]   wdog;
    logic            in_run, full, wr, rd;

    // start wins over everything else on its edge: the run restarts cleanly
    assign in_run    = (state == ST_RUN);
    assign full      = (count == CW'(DEPTH));
    assign wr        = in_run && PCWre && !start;
    assign rd        = rd_en && (count != '0) && !start;
    assign mon_state = state;
    assign done      = (state == ST_HALTED);
    assign timed_out = (state == ST_TIMEOUT);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (start) begin
            state_next = ST_RUN;
        end else if (in_run) begin
            if (PCWre && (opCode == HALT_OPCODE))
                state_next = ST_HALTED;
            else if (!PCWre && (wdog == WW'(TIMEOUT - 1)))
                state_next = ST_TIMEOUT;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr) mem[wr_ptr] <= {currentPC, DBOut};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            count       <= '0;
            overflow    <= 1'b0;
            cycle_count <= '0;
            instr_count <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            wdog        <= '0;
        end else if (start) begin
            rd_valid    <= 1'b0;
            count       <= '0;
            overflow    <= 1'b0;
            cycle_count <= '0;
            instr_count <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            wdog        <= '0;
        end else begin
            rd_valid <= rd;
            if (rd) rd_data <= mem[rd_ptr];

            if (in_run) begin
                cycle_count <= cycle_count + 32'd1;
                if (PCWre) begin
                    instr_count <= instr_count + 32'd1;
                    wdog        <= '0;
                end else begin
                    wdog <= wdog + WW'(1);
                end
            end

            if (wr) wr_ptr <= wr_ptr + AW'(1);
            // a write into a full buffer evicts the oldest entry unless a pop already took it
            if (rd || (wr && full)) rd_ptr <= rd_ptr + AW'(1);

            if (wr && !rd) begin
                if (full) overflow <= 1'b1;
                else      count    <= count + CW'(1);
            end else if (rd && !wr) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// Directed bench for cpu_trace_monitor (DEPTH=16, TIMEOUT=8) with hand-computed expectations.
module tb_cpu_trace_monitor;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        start = 1'b0;
    logic        PCWre = 1'b0;
    logic [5:0]  opCode = 6'd0;
    logic [31:0] currentPC = '0;
    logic [31:0] DBOut = '0;
    logic        rd_en = 1'b0;
    logic [63:0] rd_data;
    logic        rd_valid;
    logic [4:0]  count;
    logic        overflow;
    logic [31:0] cycle_count;
    logic [31:0] instr_count;
    logic [1:0]  mon_state;
    logic        done;
    logic        timed_out;

    int checks = 0;
    int errors = 0;

    cpu_trace_monitor #(
        .PC_WIDTH(32), .DATA_WIDTH(32), .DEPTH(16), .TIMEOUT(8), .HALT_OPCODE(6'b111111)
    ) dut (
        .CLK(CLK), .RST(RST), .start(start), .PCWre(PCWre), .opCode(opCode),
        .currentPC(currentPC), .DBOut(DBOut), .rd_en(rd_en), .rd_data(rd_data),
        .rd_valid(rd_valid), .count(count), .overflow(overflow),
        .cycle_count(cycle_count), .instr_count(instr_count), .mon_state(mon_state),
        .done(done), .timed_out(timed_out)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic commit(input logic [31:0] pc, input logic [31:0] db, input logic [5:0] op);
        PCWre = 1'b1; currentPC = pc; DBOut = db; opCode = op;
        tick();
        PCWre = 1'b0; opCode = 6'd0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick(); tick();
        RST = 1'b0;
        PCWre = 1'b1;
        repeat (3) tick();
        PCWre = 1'b0;
        checks++; if (mon_state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", mon_state); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (instr_count !== 32'd0) begin errors++; $display("FAIL reset_instr got=%0d exp=0", instr_count); end
        checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL reset_cycle got=%0d exp=0", cycle_count); end
        checks++; if ({done, timed_out, overflow, rd_valid} !== 4'b0000)
            begin errors++; $display("FAIL reset_flags got=%b exp=0000", {done, timed_out, overflow, rd_valid}); end
        checks++; if (rd_data !== 64'd0) begin errors++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
    endtask

    task automatic test_basic_trace();
        logic [63:0] exp [3];
        exp[0] = {32'h0, 32'h11}; exp[1] = {32'h4, 32'h22}; exp[2] = {32'h8, 32'h33};
        pulse_start();
        checks++; if (mon_state !== 2'd1) begin errors++; $display("FAIL basic_run_state got=%0d exp=1", mon_state); end
        commit(32'h0, 32'h11, 6'd0);
        commit(32'h4, 32'h22, 6'd0);
        commit(32'h8, 32'h33, 6'd0);
        checks++; if (count !== 5'd3) begin errors++; $display("FAIL basic_count got=%0d exp=3", count); end
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (rd_valid !== 1'b1 || rd_data !== exp[i])
                begin errors++; $display("FAIL basic_pop%0d got=%b/%h exp=1/%h", i, rd_valid, rd_data, exp[i]); end
            checks++; if (count !== 5'(2 - i)) begin errors++; $display("FAIL basic_count_pop%0d got=%0d exp=%0d", i, count, 2 - i); end
        end
        tick();
        rd_en = 1'b0;
        checks++; if (rd_valid !== 1'b0 || rd_data !== exp[2])
            begin errors++; $display("FAIL basic_empty_pop got=%b/%h exp=0/%h", rd_valid, rd_data, exp[2]); end
        checks++; if (instr_count !== 32'd3) begin errors++; $display("FAIL basic_instr got=%0d exp=3", instr_count); end
        checks++; if (cycle_count !== 32'd7) begin errors++; $display("FAIL basic_cycle got=%0d exp=7", cycle_count); end
    endtask

    task automatic test_overflow();
        pulse_start();
        for (int i = 0; i < 20; i++) commit(32'(4 * i), 32'h100 + 32'(i), 6'd0);
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovf_count got=%0d exp=16", count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        checks++; if (rd_valid !== 1'b1 || rd_data !== {32'h10, 32'h104})
            begin errors++; $display("FAIL ovf_first_pop got=%b/%h exp=1/%h", rd_valid, rd_data, {32'h10, 32'h104}); end
        checks++; if (count !== 5'd15) begin errors++; $display("FAIL ovf_count_pop got=%0d exp=15", count); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp;
        pulse_start();
        for (int i = 0; i < 16; i++) commit(32'h1000 + 32'(4 * i), 32'(i), 6'd0);
        checks++; if (count !== 5'd16 || overflow !== 1'b0)
            begin errors++; $display("FAIL b2b_full got=%0d/%b exp=16/0", count, overflow); end
        PCWre = 1'b1; currentPC = 32'h2000; DBOut = 32'hAA; rd_en = 1'b1;
        tick();
        PCWre = 1'b0;
        checks++; if (rd_valid !== 1'b1 || rd_data !== {32'h1000, 32'h0})
            begin errors++; $display("FAIL b2b_pop got=%b/%h exp=1/%h", rd_valid, rd_data, {32'h1000, 32'h0}); end
        checks++; if (count !== 5'd16 || overflow !== 1'b0)
            begin errors++; $display("FAIL b2b_count_ovf got=%0d/%b exp=16/0", count, overflow); end
        for (int k = 1; k < 17; k++) begin
            tick();
            exp = (k == 16) ? {32'h2000, 32'hAA} : {32'h1000 + 32'(4 * k), 32'(k)};
            checks++; if (rd_valid !== 1'b1 || rd_data !== exp)
                begin errors++; $display("FAIL b2b_drain%0d got=%b/%h exp=1/%h", k, rd_valid, rd_data, exp); end
        end
        rd_en = 1'b0;
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL b2b_drained got=%0d exp=0", count); end
    endtask

    task automatic test_halt();
        pulse_start();
        for (int i = 0; i < 4; i++) commit(32'h40 + 32'(4 * i), 32'h50 + 32'(i), 6'd0);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL halt_early got=%b exp=0", done); end
        commit(32'h50, 32'h54, 6'b111111);
        checks++; if (done !== 1'b1 || mon_state !== 2'd2)
            begin errors++; $display("FAIL halt_done got=%b/%0d exp=1/2", done, mon_state); end
        checks++; if (instr_count !== 32'd5 || count !== 5'd5)
            begin errors++; $display("FAIL halt_counts got=%0d/%0d exp=5/5", instr_count, count); end
        for (int i = 0; i < 3; i++) commit(32'h900, 32'h9, 6'd0);
        checks++; if (instr_count !== 32'd5 || count !== 5'd5 || cycle_count !== 32'd5)
            begin errors++; $display("FAIL halt_frozen got=%0d/%0d/%0d exp=5/5/5", instr_count, count, cycle_count); end
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        checks++; if (rd_valid !== 1'b1 || rd_data !== {32'h40, 32'h50} || count !== 5'd4)
            begin errors++; $display("FAIL halt_read got=%b/%h/%0d exp=1/%h/4", rd_valid, rd_data, count, {32'h40, 32'h50}); end
    endtask

    task automatic test_timeout_restart();
        pulse_start();
        for (int i = 0; i < 17; i++) commit(32'(i), 32'(i), 6'd0);
        checks++; if (overflow !== 1'b1 || count !== 5'd16)
            begin errors++; $display("FAIL to_prefill got=%b/%0d exp=1/16", overflow, count); end
        repeat (7) tick();
        checks++; if (timed_out !== 1'b0 || mon_state !== 2'd1)
            begin errors++; $display("FAIL to_idle7 got=%b/%0d exp=0/1", timed_out, mon_state); end
        tick();
        checks++; if (timed_out !== 1'b1 || mon_state !== 2'd3)
            begin errors++; $display("FAIL to_idle8 got=%b/%0d exp=1/3", timed_out, mon_state); end
        checks++; if (cycle_count !== 32'd25) begin errors++; $display("FAIL to_cycle got=%0d exp=25", cycle_count); end
        repeat (3) tick();
        checks++; if (cycle_count !== 32'd25 || mon_state !== 2'd3)
            begin errors++; $display("FAIL to_frozen got=%0d/%0d exp=25/3", cycle_count, mon_state); end
        start = 1'b1; rd_en = 1'b1;
        tick();
        start = 1'b0; rd_en = 1'b0;
        checks++; if (mon_state !== 2'd1 || timed_out !== 1'b0)
            begin errors++; $display("FAIL restart_state got=%0d/%b exp=1/0", mon_state, timed_out); end
        checks++; if (cycle_count !== 32'd0 || instr_count !== 32'd0 || count !== 5'd0 || overflow !== 1'b0)
            begin errors++; $display("FAIL restart_clear got=%0d/%0d/%0d/%b exp=0/0/0/0", cycle_count, instr_count, count, overflow); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL restart_rd_valid got=%b exp=0", rd_valid); end
    endtask

    task automatic test_reset_midrun();
        for (int i = 0; i < 17; i++) commit(32'h300 + 32'(i), 32'h7, 6'd0);
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        checks++; if (rd_valid !== 1'b1 || overflow !== 1'b1)
            begin errors++; $display("FAIL mid_pre got=%b/%b exp=1/1", rd_valid, overflow); end
        #2 RST = 1'b1;
        #1;
        checks++; if (mon_state !== 2'd0 || count !== 5'd0 || rd_valid !== 1'b0 || rd_data !== 64'd0)
            begin errors++; $display("FAIL mid_async got=%0d/%0d/%b/%h exp=0/0/0/0", mon_state, count, rd_valid, rd_data); end
        checks++; if (cycle_count !== 32'd0 || instr_count !== 32'd0 || overflow !== 1'b0 || done !== 1'b0 || timed_out !== 1'b0)
            begin errors++; $display("FAIL mid_async_cnt got=%0d/%0d/%b/%b/%b exp=0/0/0/0/0", cycle_count, instr_count, overflow, done, timed_out); end
        tick();
        RST = 1'b0;
        tick();
        checks++; if (mon_state !== 2'd0) begin errors++; $display("FAIL mid_after got=%0d exp=0", mon_state); end
    endtask

    initial begin
        test_reset();
        test_basic_trace();
        test_overflow();
        test_back_to_back();
        test_halt();
        test_timeout_restart();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
